// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter sharing one combinational IEEE-754
// double multiplier among NUM_REQ requesters, with an operand register and a
// result register. Define FP_MUL_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no round-robin pointer).

module fp_multiplier (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] y
);

  logic              sa, sb, sign;
  logic [10:0]       ea, eb, ea_eff, eb_eff;
  logic [51:0]       fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [52:0]       ma, mb;
  logic [105:0]      prod, norm, shifted;
  logic [6:0]        lzc;
  logic              found;
  logic signed [13:0] er;
  logic [13:0]       sh;
  logic [6:0]        sh_c;
  logic [233:0]      wide;
  logic              guard, sticky, round_up, ovf;
  logic [62:0]       mag, res;

  // Unpack, multiply significands, normalise, round to nearest even, and
  // resolve the special operands (NaN, infinity, zero) last.
  always_comb begin
    sa = a[63];
    sb = b[63];
    ea = a[62:52];
    eb = b[62:52];
    fa = a[51:0];
    fb = b[51:0];
    sign   = sa ^ sb;
    a_nan  = (ea == 11'h7FF) && (fa != 52'd0);
    b_nan  = (eb == 11'h7FF) && (fb != 52'd0);
    a_inf  = (ea == 11'h7FF) && (fa == 52'd0);
    b_inf  = (eb == 11'h7FF) && (fb == 52'd0);
    a_zero = (ea == 11'd0) && (fa == 52'd0);
    b_zero = (eb == 11'd0) && (fb == 52'd0);

    // Subnormals have no hidden bit but share the minimum exponent of 1
    ma     = {ea != 11'd0, fa};
    mb     = {eb != 11'd0, fb};
    ea_eff = (ea == 11'd0) ? 11'd1 : ea;
    eb_eff = (eb == 11'd0) ? 11'd1 : eb;
    prod   = {53'd0, ma} * {53'd0, mb};

    lzc   = 7'd0;
    found = 1'b0;
    for (int i = 105; i >= 0; i--) begin
      if (!found && prod[i]) begin
        lzc   = 7'(105 - i);
        found = 1'b1;
      end
    end
    norm = prod << lzc;

    // Bit 105 of norm carries weight 2^1 relative to the exponent sum
    er = $signed({3'b000, ea_eff}) + $signed({3'b000, eb_eff})
         - 14'sd1022 - $signed({7'd0, lzc});

    sh      = 14'(14'sd1 - er);
    sh_c    = (sh > 14'd127) ? 7'd127 : sh[6:0];
    wide    = {norm, 128'd0} >> sh_c;
    shifted = wide[233:128];
    ovf     = 1'b0;

    if (er >= 14'sd1) begin
      ovf    = (er >= 14'sd2047);
      mag    = {er[10:0], norm[104:53]};
      guard  = norm[52];
      sticky = |norm[51:0];
    end else begin
      // Denormalise; a rounding carry into bit 52 lands in the exponent field
      mag    = {10'd0, shifted[105:53]};
      guard  = shifted[52];
      sticky = (|shifted[51:0]) | (|wide[127:0]);
    end

    round_up = guard & (sticky | mag[0]);
    res      = mag + {62'd0, round_up};

    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      y = 64'h7FF8_0000_0000_0000;
    end else if (a_inf || b_inf || ovf) begin
      y = {sign, 11'h7FF, 52'd0};
    end else if (a_zero || b_zero) begin
      y = {sign, 63'd0};
    end else begin
      y = {sign, res};
    end
  end

endmodule

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [64*NUM_REQ-1:0]   req_a,
  input  logic [64*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_result
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant_oh;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               s1_adv, s2_adv, accept, s2_load;

  logic               s1_valid_q, s1_valid_d;
  logic [63:0]        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [63:0]        mul_y;

`ifndef FP_MUL_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  fp_multiplier u_fp_multiplier (
    .a (s1_a_q),
    .b (s1_b_q),
    .y (mul_y)
  );

  assign s2_adv  = !rsp_valid_q || rsp_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign accept  = grant_any && s1_adv;
  assign s2_load = s1_valid_q && s2_adv;

  // Pick one requester: first valid at or after rr_ptr (or lowest index)
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!grant_any && req_valid[idx]) begin
        grant_any     = 1'b1;
        grant_idx     = PTR_W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  // Ready is held low during reset even though the empty pipe could accept
  assign req_ready = grant_oh & {NUM_REQ{s1_adv && rst_n}};

  // Next-state for both pipeline stages and the round-robin pointer
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_id_d      = s1_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[64*grant_idx +: 64];
      s1_b_d     = req_b[64*grant_idx +: 64];
      s1_id_d    = ID_W'(grant_idx);
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
      rr_ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = mul_y;
      rsp_id_d     = s1_id_q;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // Pipeline and pointer registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_id_q      <= s1_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
`ifndef FP_MUL_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed vectors for fp_mul_arbiter (default
// round-robin build, NUM_REQ=4, ID_W=2). Inputs change and outputs are
// sampled around the falling edge of clk.

module tb_fp_mul_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [64*N-1:0] req_a;
  logic [64*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [63:0]    rsp_result;

  logic [63:0] op_a [N];
  logic [63:0] op_b [N];
  logic [63:0] t2_prod [N];

  int vec_count;
  int miss_count;

  fp_mul_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-requester operand tables onto the wide buses
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[64*i +: 64] = op_a[i];
      req_b[64*i +: 64] = op_b[i];
    end
  end

  task automatic applyStimulus(input int idx, input logic [63:0] a, input logic [63:0] b);
    op_a[idx] = a;
    op_b[idx] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    for (int i = 0; i < N; i++) applyStimulus(i, 64'd0, 64'd0);
    t2_prod[0] = 64'h3FF8_0000_0000_0000;  // 1.0 * 1.5
    t2_prod[1] = 64'h4008_0000_0000_0000;  // 2.0 * 1.5
    t2_prod[2] = 64'h4012_0000_0000_0000;  // 3.0 * 1.5
    t2_prod[3] = 64'h4018_0000_0000_0000;  // 4.0 * 1.5
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;

    // Reset state with every requester asking
    @(negedge clk); #1;
    checkOutput("reset_ready",     64'(req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_result",    rsp_result,     64'd0);
    checkOutput("reset_id",        64'(rsp_id),    64'd0);

    // Single request 3.0 * 2.5 from requester 1
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 64'h4008_0000_0000_0000, 64'h4004_0000_0000_0000);
    req_valid = 4'b0010;
    #1 checkOutput("t1_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = '0;
    #1 checkOutput("t1_stage1_only", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1;
    checkOutput("t1_valid",  64'(rsp_valid), 64'd1);
    checkOutput("t1_result", rsp_result,     64'h401E_0000_0000_0000);
    checkOutput("t1_id",     64'(rsp_id),    64'd1);
    @(negedge clk); #1;
    checkOutput("t1_drained", 64'(rsp_valid), 64'd0);

    // Short reset so the round-robin pointer restarts at 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all four valid, results stream out one per cycle
    applyStimulus(0, 64'h3FF0_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    applyStimulus(1, 64'h4000_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    applyStimulus(2, 64'h4008_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    applyStimulus(3, 64'h4010_0000_0000_0000, 64'h3FF8_0000_0000_0000);
    req_valid = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) req_valid = '0;
      #1;
      if (c < 5) checkOutput($sformatf("t2_grant%0d", c), 64'(req_ready), 64'(1 << (c % 4)));
      if (c >= 2) begin
        checkOutput($sformatf("t2_valid%0d", c),  64'(rsp_valid), 64'd1);
        checkOutput($sformatf("t2_id%0d", c),     64'(rsp_id),    64'((c - 2) % 4));
        checkOutput($sformatf("t2_result%0d", c), rsp_result,     t2_prod[(c - 2) % 4]);
      end
      @(negedge clk);
    end
    #1 checkOutput("t2_drained", 64'(rsp_valid), 64'd0);

    // Backpressure: 0.5*0.5 (req 1) then -2.0*4.0 (req 2) with consumer stalled
    rsp_ready = 1'b0;
    applyStimulus(1, 64'h3FE0_0000_0000_0000, 64'h3FE0_0000_0000_0000);
    req_valid = 4'b0010;
    #1 checkOutput("t3_ready_a", 64'(req_ready), 64'h2);
    @(negedge clk);
    applyStimulus(2, 64'hC000_0000_0000_0000, 64'h4010_0000_0000_0000);
    req_valid = 4'b0100;
    #1 checkOutput("t3_ready_b", 64'(req_ready), 64'h4);
    @(negedge clk);
    // Requesters 3 (-1.0*0.0) and 0 (2.0*2.0) wait behind the stall
    applyStimulus(3, 64'hBFF0_0000_0000_0000, 64'h0000_0000_0000_0000);
    applyStimulus(0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
    req_valid = 4'b1001;
    for (int s = 0; s < 5; s++) begin
      #1;
      checkOutput($sformatf("t3_stall_ready%0d", s),  64'(req_ready), 64'd0);
      checkOutput($sformatf("t3_stall_valid%0d", s),  64'(rsp_valid), 64'd1);
      checkOutput($sformatf("t3_stall_result%0d", s), rsp_result,     64'h3FD0_0000_0000_0000);
      checkOutput($sformatf("t3_stall_id%0d", s),     64'(rsp_id),    64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 checkOutput("t4_grant3", 64'(req_ready), 64'h8);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    checkOutput("t3_second_result", rsp_result,     64'hC020_0000_0000_0000);
    checkOutput("t3_second_id",     64'(rsp_id),    64'd2);
    checkOutput("t4_wrap_grant0",   64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("t4_result", rsp_result,  64'h8000_0000_0000_0000);
    checkOutput("t4_id",     64'(rsp_id), 64'd3);
    @(negedge clk); #1;
    checkOutput("t4_next_result", rsp_result,  64'h4010_0000_0000_0000);
    checkOutput("t4_next_id",     64'(rsp_id), 64'd0);
    @(negedge clk); #1;
    checkOutput("t4_drained", 64'(rsp_valid), 64'd0);

    // Smallest normal times 2.0 from requester 2; pointer moves to 3 only
    applyStimulus(2, 64'h0010_0000_0000_0000, 64'h4000_0000_0000_0000);
    req_valid = 4'b0100;
    #1 checkOutput("t6_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = 4'b1111;
    #1 checkOutput("t6_ptr_after_grant", 64'(req_ready), 64'h8);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("t6_result", rsp_result,  64'h0020_0000_0000_0000);
    checkOutput("t6_id",     64'(rsp_id), 64'd2);
    @(negedge clk); #1;
    checkOutput("t6_follow_id", 64'(rsp_id), 64'd3);
    @(negedge clk);

    // Fill both stages, then reset asynchronously between clock edges
    rsp_ready = 1'b0;
    applyStimulus(0, 64'h4008_0000_0000_0000, 64'h4004_0000_0000_0000);
    req_valid = 4'b0001;
    #1 checkOutput("t5_ready_a", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b0010;
    #1 checkOutput("t5_ready_b", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = '0;
    #1 checkOutput("t5_full_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checkOutput("t5_rst_valid",  64'(rsp_valid), 64'd0);
    checkOutput("t5_rst_result", rsp_result,     64'd0);
    checkOutput("t5_rst_id",     64'(rsp_id),    64'd0);
    checkOutput("t5_rst_ready",  64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(2, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000);
    req_valid = 4'b0100;
    #1 checkOutput("t5_post_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = '0;
    #1 checkOutput("t5_post_stage1", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1;
    checkOutput("t5_post_valid",  64'(rsp_valid), 64'd1);
    checkOutput("t5_post_result", rsp_result,     64'h3FF0_0000_0000_0000);
    checkOutput("t5_post_id",     64'(rsp_id),    64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

- Shares one combinational double-precision `fp_multiplier` (64-bit A, B, result) among `NUM_REQ` requesters.
- Round-robin arbitration of valid/ready requests into a two-stage pipeline: operand register, then result register.
- Returns each product on a single response channel, tagged with the requester index.
- Sits between FPU issue logic and the multiplier datapath; the only instantiation point of `fp_multiplier`.

## Interface

**Parameters**

- `NUM_REQ`, default 4 — number of requesters, 2..8.
- `ID_W`, default 2 — response tag width; must be ≥ clog2(`NUM_REQ`).

**Ports**

- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  — per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  — per-requester accept; at most one bit high.
- `req_a`  in  64*`NUM_REQ`  — operand A, IEEE-754 double; requester i at bits [64i+63:64i].
- `req_b`  in  64*`NUM_REQ`  — operand B, same packing.
- `rsp_valid`  out  1  — result valid.
- `rsp_ready`  in  1  — consumer accept.
- `rsp_id`  out  `ID_W`  — index of the requester that issued the result.
- `rsp_result`  out  64  — product from `fp_multiplier`, passed through unmodified.

## Operation

**Arbitration**

- The grant is combinational.
- In round-robin mode, the grant goes to the first requester with `req_valid` high, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- `req_ready[g]` = grant[g] & `s1_adv`.
- `s1_adv` = !`s1_valid` | `s2_adv`.
- `s2_adv` = !`rsp_valid` | `rsp_ready`.

**Handshake**

- A request is accepted on a clock edge where `req_valid[g]` & `req_ready[g]`.
- On acceptance: `rr_ptr` ← (g+1) mod `NUM_REQ`, including the wrap from `NUM_REQ`-1 to 0.
- With no acceptance, `rr_ptr` holds.
- A requester must hold `req_a`, `req_b` and `req_valid` stable until accepted.

**Stage 1**

- On acceptance, `req_a`/`req_b` of g and tag g are captured into the operand register, and `s1_valid` is set.
- `s1_valid` clears when stage 1 advances with no new acceptance.
- The operand register drives `fp_multiplier`.

**Stage 2**

- When `s1_valid` & `s2_adv`: the multiplier output is captured into `rsp_result`, the tag into `rsp_id`, and `rsp_valid` is set.
- `rsp_valid` clears on `rsp_ready` when no new result enters.

**Backpressure**

- `rsp_valid` & !`rsp_ready` freezes stage 2.
- A full stage 1 then also freezes, and all `req_ready` bits go low.
- While stalled, `rsp_result`/`rsp_id` hold stable.

**Simultaneous events**

- Accept, stage-1 advance and response pop may all occur in one cycle; no bubble is inserted.
- With `req_valid` all-zero, no grant is issued and `rr_ptr` is unchanged.

**Reset** (async assert, any time, including mid-transaction)

- `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0.
- `s1_valid`=0, `rr_ptr`=0.
- All in-flight operations are discarded.
- `req_ready` is 0 while `rst_n` is low.
- After deassertion, the first acceptance is possible on the first clock edge.

## Timing

- Latency: accepted at edge N, `rsp_valid` high after edge N+1 (2-cycle issue-to-result), assuming no stall.
- Throughput: one result per cycle when `rsp_ready` is held high.
- The combinational path `req_valid` → `req_ready` passes through the arbiter only.
- `rsp_ready` → `req_ready` is a combinational path.
- The multiplier path is register-to-register (operand register to result register).

## Configuration

- Macro: `FP_MUL_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority, lowest index wins; `rr_ptr` logic is removed and acceptance ignores history.
- **Undefined (default):** round-robin as described under Operation.

## Test plan

1. Single request, 3.0 × 2.5:
   - Stimulus: requester 1 presents A=4008000000000000, B=4004000000000000 → accepted at edge 0.
   - Required: `rsp_valid` high after edge 1, `rsp_result`=401E000000000000, `rsp_id`=1.
2. Round-robin fairness:
   - Stimulus: all four `req_valid` held high, `rsp_ready`=1, each requester with distinct operands.
   - Required: grant order is 0,1,2,3,0; back-to-back results one per cycle, with `rsp_id` in the same order.
   - Under `FP_MUL_ARB_FIXED_PRIO_EN`: requester 0 wins every cycle.
3. Backpressure, using 0.5×0.5 then −2.0×4.0:
   - Stimulus: issue both products, hold `rsp_ready`=0 for 5 cycles.
   - Required: `rsp_result` holds 3FD0000000000000; all `req_ready`=0 once stage 1 is full.
   - Required: after `rsp_ready`=1, the next result is C020000000000000, in order and with no loss.
4. Wrap-around and signed zero:
   - Stimulus: `rr_ptr` at 3, requester 3 issues −1.0×0.0 (BFF0000000000000, 0000000000000000).
   - Required: result 8000000000000000, `rsp_id`=3, and requester 0 is granted next.
5. Reset mid-flight:
   - Stimulus: assert `rst_n`=0 asynchronously with both stages full.
   - Required: `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0 immediately.
   - Required: after release, 1.0×1.0 from requester 2 returns 3FF0000000000000 with `rsp_id`=2 two cycles after acceptance.
6. Subnormal boundary:
   - Stimulus: 0010000000000000 × 4000000000000000 issued while other requesters are idle.
   - Required: result 0020000000000000 and `rr_ptr` advances past the grantee only.
